// File: rtl/vga_sync_decoder.sv
// Recovers VGA raster timing from sampled hsync/vsync/rgb, locks after good frames, emits pixel coordinates.
// Latency: a sample taken at en-cycle N drives column/line/pixel_rgb/pixel_valid at en-cycle N+2.
// Backpressure: none; en acts as a pixel strobe, and all state and outputs hold while it is low.
module vga_sync_decoder #(
    parameter int HVA         = 640,
    parameter int HSP         = 96,
    parameter int HBP         = 48,
    parameter int HWL         = 800,
    parameter int VVA         = 480,
    parameter int VSP         = 2,
    parameter int VBP         = 33,
    parameter int VWF         = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    output logic [11:0] column,
    output logic [11:0] line,
    output logic        pixel_valid,
    output logic [11:0] pixel_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic [11:0] h_meas,
    output logic [11:0] v_meas,
    output logic [7:0]  err_cnt
);

    localparam logic [11:0] H_START = 12'(HSP + HBP);
    localparam logic [11:0] H_END   = 12'(HSP + HBP + HVA);
    localparam logic [11:0] V_START = 12'(VSP + VBP);
    localparam logic [11:0] V_END   = 12'(VSP + VBP + VVA);
    localparam logic [11:0] HWL_C   = 12'(HWL);
    localparam logic [11:0] HSP_C   = 12'(HSP);
    localparam logic [11:0] VWF_C   = 12'(VWF);
    localparam logic [11:0] VSP_C   = 12'(VSP);
    localparam logic [11:0] H_TOUT  = 12'(2 * HWL);
    localparam logic [11:0] CNT_MAX = 12'hFFF;
    localparam logic [3:0]  LOCK_C  = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Sample registers: stage 1 holds the newest sample, stage 2 the one before it.
    logic        hs1, vs1, hs2, vs2;
    logic [11:0] rgb1, rgb2;

    // Raster counters and measurement state.
    logic [11:0] hcnt, vcnt, hlow, vlow;
    logic        hw_ok, vw_ok, v_pend, frame_bad;

    // FSM.
    state_t      state, state_nxt;
    logic [3:0]  good_cnt, good_nxt;
    logic        err_inc;

    // Derived per-sample events.
    logic        h_fall, h_rise, v_fall, v_rise, boundary;
    logic [11:0] hcnt_inc, vcnt_inc, hlow_inc, vlow_inc;
    logic        line_bad, frame_good, timeout, visible;

    assign h_fall   = hs2 & ~hs1;
    assign h_rise   = ~hs2 & hs1;
    assign v_fall   = vs2 & ~vs1;
    assign v_rise   = ~vs2 & vs1;
    // A pending or simultaneous vsync fall is consumed by the hsync fall that starts the frame.
    assign boundary = h_fall & (v_pend | v_fall);

    assign hcnt_inc = (hcnt == CNT_MAX) ? hcnt : hcnt + 12'd1;
    assign vcnt_inc = (vcnt == CNT_MAX) ? vcnt : vcnt + 12'd1;
    assign hlow_inc = (hlow == CNT_MAX) ? hlow : hlow + 12'd1;
    assign vlow_inc = (vlow == CNT_MAX) ? vlow : vlow + 12'd1;

    // The line that ends at this hsync fall: its length and the width of its own sync pulse.
    assign line_bad   = (hcnt_inc != HWL_C) | ~hw_ok;
    assign frame_good = ~frame_bad & ~line_bad & (vcnt_inc == VWF_C) & vw_ok;
    // hcnt only passes 2*HWL once per missing-sync episode, so this fires a single time.
    assign timeout    = ~h_fall & (hcnt_inc == H_TOUT);

    assign visible = (hcnt >= H_START) && (hcnt < H_END) &&
                     (vcnt >= V_START) && (vcnt < V_END);

    // Capture inputs and keep the previous capture for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs1  <= 1'b1;
            vs1  <= 1'b1;
            hs2  <= 1'b1;
            vs2  <= 1'b1;
            rgb1 <= '0;
            rgb2 <= '0;
        end else if (en) begin
            hs1  <= hsync;
            vs1  <= vsync;
            rgb1 <= rgb;
            hs2  <= hs1;
            vs2  <= vs1;
            rgb2 <= rgb1;
        end
    end

    // Horizontal/vertical position counters, line/frame measurement and pulse width tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt      <= '0;
            vcnt      <= '0;
            hlow      <= '0;
            vlow      <= '0;
            hw_ok     <= 1'b0;
            vw_ok     <= 1'b0;
            v_pend    <= 1'b0;
            frame_bad <= 1'b0;
            h_meas    <= '0;
            v_meas    <= '0;
        end else if (en) begin
            if (h_fall) begin
                hcnt   <= '0;
                h_meas <= hcnt_inc;
            end else begin
                hcnt <= hcnt_inc;
            end

            if (~hs1) begin
                hlow <= h_fall ? 12'd1 : hlow_inc;
            end
            if (h_rise) begin
                hw_ok <= (hlow == HSP_C);
            end

            if (boundary) begin
                vcnt   <= '0;
                v_meas <= vcnt_inc;
                v_pend <= 1'b0;
                vlow   <= ~vs1 ? 12'd1 : 12'd0;
            end else begin
                if (h_fall) begin
                    vcnt <= vcnt_inc;
                end
                if (v_fall) begin
                    v_pend <= 1'b1;
                end
                if (h_fall & ~vs1) begin
                    vlow <= vlow_inc;
                end
            end
            if (v_rise) begin
                vw_ok <= (vlow == VSP_C);
            end

            if (boundary) begin
                frame_bad <= 1'b0;
            end else if (h_fall & line_bad) begin
                frame_bad <= 1'b1;
            end
        end
    end

    // Lock FSM next state: frame boundaries drive SEARCH/CHECK, bad lines or frames drop LOCKED.
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        err_inc   = 1'b0;
        case (state)
            SEARCH: begin
                if (boundary) begin
                    state_nxt = CHECK;
                    good_nxt  = '0;
                end
            end
            CHECK: begin
                if (boundary) begin
                    if (frame_good) begin
                        good_nxt = good_cnt + 4'd1;
                        if (good_cnt + 4'd1 == LOCK_C) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
            end
            LOCKED: begin
                if ((h_fall & line_bad) | (boundary & ~frame_good)) begin
                    state_nxt = CHECK;
                    good_nxt  = '0;
                    err_inc   = 1'b1;
                end
            end
            default: begin
                state_nxt = SEARCH;
                good_nxt  = '0;
            end
        endcase
        if (timeout) begin
            state_nxt = SEARCH;
            good_nxt  = '0;
            err_inc   = (state == LOCKED);
        end
    end

    // Lock FSM state, registered lock flag and saturating violation count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SEARCH;
            good_cnt <= '0;
            locked   <= 1'b0;
            err_cnt  <= '0;
        end else if (en) begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            locked   <= (state_nxt == LOCKED);
            if (err_inc && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // Output stage: visible coordinates, colour and qualifiers for the sample the counters describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            column      <= '0;
            line        <= '0;
            pixel_valid <= 1'b0;
            pixel_rgb   <= '0;
            frame_start <= 1'b0;
        end else if (en) begin
            column      <= visible ? hcnt - H_START : 12'd0;
            line        <= visible ? vcnt - V_START : 12'd0;
            pixel_valid <= visible & locked;
            pixel_rgb   <= rgb2;
            frame_start <= visible & locked & (hcnt == H_START) & (vcnt == V_START);
        end
    end

endmodule
